// File: rtl/tdes_pass_sequencer.sv
// Drives one shared single-DES core through the three EDE passes of Triple DES.
// Optional build macro TDES_KEY12_SHORTCUT_EN: collapse degenerate key sets to a single pass.
module tdes_pass_sequencer #(
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              enable,
  input  logic              encryptionType,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] key1,
  input  logic [DATA_W-1:0] key2,
  input  logic [DATA_W-1:0] key3,
  output logic              des_start,
  output logic              des_decrypt,
  output logic [DATA_W-1:0] des_key,
  output logic [DATA_W-1:0] des_din,
  input  logic              des_done,
  input  logic [DATA_W-1:0] des_dout,
  output logic [DATA_W-1:0] outputData,
  output logic              outputEnable,
  output logic              busy,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [1:0]          pass_q, pass_d;
  logic [CNT_W-1:0]    wd_q, wd_d;
  logic                enc_q, enc_d;
  logic [DATA_W-1:0]   key1_q, key1_d;
  logic [DATA_W-1:0]   key2_q, key2_d;
  logic [DATA_W-1:0]   key3_q, key3_d;
  logic [DATA_W-1:0]   block_q, block_d;
  logic                des_start_q, des_start_d;
  logic                des_decrypt_q, des_decrypt_d;
  logic [DATA_W-1:0]   des_key_q, des_key_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_en_q, out_en_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;
  logic [1:0]          first_pass;
  logic [CNT_W-1:0]    wd_inc;

  // Encrypt walks key1,key2,key3 as E,D,E; decrypt walks key3,key2,key1 as D,E,D.
  function automatic logic [DATA_W-1:0] pass_key(input logic enc, input logic [1:0] p,
                                                  input logic [DATA_W-1:0] k1,
                                                  input logic [DATA_W-1:0] k2,
                                                  input logic [DATA_W-1:0] k3);
    logic [DATA_W-1:0] k;
    if (p == 2'd1)  k = k2;
    else if (p == 2'd0) k = enc ? k1 : k3;
    else                k = enc ? k3 : k1;
    return k;
  endfunction

  function automatic logic pass_dec(input logic enc, input logic [1:0] p);
    return enc ? (p == 2'd1) : (p != 2'd1);
  endfunction

  always_comb begin
`ifdef TDES_KEY12_SHORTCUT_EN
    // E(k1) followed by D(k1) cancels out, so only the outer pass is needed.
    if ((encryptionType && (key1 == key2)) || (!encryptionType && (key2 == key3)))
      first_pass = 2'd2;
    else
      first_pass = 2'd0;
`else
    first_pass = 2'd0;
`endif
  end

  assign wd_inc = wd_q + 1'b1;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d       = state_q;
    pass_d        = pass_q;
    wd_d          = wd_q;
    enc_d         = enc_q;
    key1_d        = key1_q;
    key2_d        = key2_q;
    key3_d        = key3_q;
    block_d       = block_q;
    des_start_d   = 1'b0;
    des_decrypt_d = des_decrypt_q;
    des_key_d     = des_key_q;
    out_data_d    = out_data_q;
    out_en_d      = 1'b0;
    busy_d        = busy_q;
    error_d       = error_q;

    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (enable) begin
          enc_d         = encryptionType;
          key1_d        = key1;
          key2_d        = key2;
          key3_d        = key3;
          block_d       = data;
          pass_d        = first_pass;
          busy_d        = 1'b1;
          error_d       = 1'b0;
          des_start_d   = 1'b1;
          des_key_d     = pass_key(encryptionType, first_pass, key1, key2, key3);
          des_decrypt_d = pass_dec(encryptionType, first_pass);
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (des_done) begin
          block_d = des_dout;
          if (pass_q == 2'd2) begin
            out_data_d = des_dout;
            out_en_d   = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_DONE;
          end else begin
            pass_d        = pass_q + 2'd1;
            des_start_d   = 1'b1;
            des_key_d     = pass_key(enc_q, pass_q + 2'd1, key1_q, key2_q, key3_q);
            des_decrypt_d = pass_dec(enc_q, pass_q + 2'd1);
            state_d       = S_ISSUE;
          end
        end else begin
          wd_d = wd_inc;
          if (wd_inc == TIMEOUT_W) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_ERROR;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      state_q       <= S_IDLE;
      pass_q        <= '0;
      wd_q          <= '0;
      enc_q         <= 1'b0;
      key1_q        <= '0;
      key2_q        <= '0;
      key3_q        <= '0;
      block_q       <= '0;
      des_start_q   <= 1'b0;
      des_decrypt_q <= 1'b0;
      des_key_q     <= '0;
      out_data_q    <= '0;
      out_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pass_q        <= pass_d;
      wd_q          <= wd_d;
      enc_q         <= enc_d;
      key1_q        <= key1_d;
      key2_q        <= key2_d;
      key3_q        <= key3_d;
      block_q       <= block_d;
      des_start_q   <= des_start_d;
      des_decrypt_q <= des_decrypt_d;
      des_key_q     <= des_key_d;
      out_data_q    <= out_data_d;
      out_en_q      <= out_en_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
    end
  end

  assign des_start    = des_start_q;
  assign des_decrypt  = des_decrypt_q;
  assign des_key      = des_key_q;
  assign des_din      = block_q;
  assign outputData   = out_data_q;
  assign outputEnable = out_en_q;
  assign busy         = busy_q;
  assign error        = error_q;

endmodule
